// File: rtl/step_playback_engine_if.sv
// step_playback_engine_if: control/pattern inputs and playback outputs of the step playback engine
// master: sequencer/UI side driving mode, play_btn, tempo pulses and patterns; reads triggers and status
// slave : playback engine; i_* inputs, o_* registered outputs (trig, step_tick, step index, playing, period)
interface step_playback_engine_if #(parameter int CNT_W = 24);
  logic [1:0]       i_mode;
  logic             i_play_btn;
  logic             i_tempo_faster;
  logic             i_tempo_slower;
  logic [7:0][3:0]  i_seq_smpl;
  logic [3:0]       o_trig;
  logic             o_step_tick;
  logic [2:0]       o_play_step_idx;
  logic             o_playing;
  logic [CNT_W-1:0] o_period;
  modport master (output i_mode, i_play_btn, i_tempo_faster, i_tempo_slower, i_seq_smpl,
                  input  o_trig, o_step_tick, o_play_step_idx, o_playing, o_period);
  modport slave  (input  i_mode, i_play_btn, i_tempo_faster, i_tempo_slower, i_seq_smpl,
                  output o_trig, o_step_tick, o_play_step_idx, o_playing, o_period);
endinterface

// File: rtl/step_playback_engine.sv
// step_playback_engine: walks eight 4-bit step patterns at a programmable tempo, pulsing voice triggers
// clk, rst (sync, active-high); bus (slave): mode/play_btn/tempo pulses/patterns in,
// trig/step_tick/play_step_idx/playing/period out, all registered
module step_playback_engine #(
  parameter int CNT_W          = 24,
  parameter int DEFAULT_PERIOD = 6_250_000,
  parameter int MIN_PERIOD     = 1_000_000,
  parameter int MAX_PERIOD     = 12_500_000,
  parameter int PERIOD_STEP    = 250_000
) (
  input logic clk,
  input logic rst,
  step_playback_engine_if.slave bus
);
  typedef enum logic [1:0] {STOPPED, PLAYING, PAUSED} state_t;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_P = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] STP   = CNT_W'(PERIOD_STEP);
  localparam logic [CNT_W:0]   MIN_X = (CNT_W+1)'(MIN_PERIOD);
  localparam logic [CNT_W:0]   MAX_X = (CNT_W+1)'(MAX_PERIOD);
  localparam logic [CNT_W:0]   STP_X = (CNT_W+1)'(PERIOD_STEP);
  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_tick_cnt, w_tick_cnt, r_period, w_period;
  logic [CNT_W:0]   w_inc;
  logic [2:0]       r_idx, w_idx;
  logic [3:0]       r_trig, w_trig;
  logic             r_step_tick, w_step_tick, r_playing, w_adv;
  // Wide add so the sum cannot wrap before the clamp; the decrement side clamps before subtracting.
  assign w_inc = {1'b0, r_period} + STP_X;
  always_comb begin
    w_state     = r_state;
    w_tick_cnt  = r_tick_cnt;
    w_idx       = r_idx;
    w_trig      = '0;
    w_step_tick = 1'b0;
    // >= rather than == so a freshly shortened period below tick_cnt advances instead of wrapping.
    w_adv       = r_tick_cnt >= r_period - ONE;
    w_period    = (bus.i_tempo_faster && !bus.i_tempo_slower) ?
                    (({1'b0, r_period} < MIN_X + STP_X) ? MIN_P : r_period - STP) :
                  (bus.i_tempo_slower && !bus.i_tempo_faster) ?
                    ((w_inc > MAX_X) ? MAX_P : w_inc[CNT_W-1:0]) : r_period;
    if (bus.i_mode != 2'd1) begin
      w_state    = STOPPED;
      w_tick_cnt = '0;
      w_idx      = '0;
    end else if (r_state == STOPPED) begin
      if (bus.i_play_btn) begin
        w_state     = PLAYING;
        w_tick_cnt  = '0;
        w_idx       = '0;
        w_trig      = bus.i_seq_smpl[0];
        w_step_tick = 1'b1;
      end
    end else if (r_state == PAUSED) begin
      w_state = bus.i_play_btn ? PLAYING : PAUSED;
    end else begin
      w_tick_cnt = w_adv ? '0 : r_tick_cnt + ONE;
      if (w_adv) begin
        w_idx       = r_idx + 3'd1;
        w_trig      = bus.i_seq_smpl[r_idx + 3'd1];
        w_step_tick = 1'b1;
      end
      w_state = bus.i_play_btn ? PAUSED : PLAYING;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= STOPPED;
      r_tick_cnt  <= '0;
      r_idx       <= '0;
      r_trig      <= '0;
      r_step_tick <= 1'b0;
      r_playing   <= 1'b0;
      r_period    <= DEF_P;
    end else begin
      r_state     <= w_state;
      r_tick_cnt  <= w_tick_cnt;
      r_idx       <= w_idx;
      r_trig      <= w_trig;
      r_step_tick <= w_step_tick;
      r_playing   <= w_state == PLAYING;
      r_period    <= w_period;
    end
  end
  assign bus.o_trig          = r_trig;
  assign bus.o_step_tick     = r_step_tick;
  assign bus.o_play_step_idx = r_idx;
  assign bus.o_playing       = r_playing;
  assign bus.o_period        = r_period;
endmodule

// File: tb/tb_step_playback_engine.sv
// tb_step_playback_engine: directed and random stimulus checked against a behavioural playback model
module tb_step_playback_engine;
  localparam int CW = 4, DP = 4, MINP = 2, MAXP = 8, PS = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  step_playback_engine_if #(.CNT_W(CW)) bus();
  step_playback_engine #(.CNT_W(CW), .DEFAULT_PERIOD(DP), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP),
                         .PERIOD_STEP(PS)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_vec = 0, n_err = 0;
  int m_st, m_pos, m_idx, m_period, m_trig, m_tick;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int pat(input int i);
    return int'((bus.i_seq_smpl >> (4 * i)) & 32'hF);
  endfunction
  function automatic void model_step();
    int np = m_period;
    if (rst) begin
      m_st = 0; m_pos = 0; m_idx = 0; m_period = DP; m_trig = 0; m_tick = 0;
      return;
    end
    m_trig = 0; m_tick = 0;
    if (bus.i_tempo_faster && !bus.i_tempo_slower) np = (m_period - PS < MINP) ? MINP : m_period - PS;
    if (bus.i_tempo_slower && !bus.i_tempo_faster) np = (m_period + PS > MAXP) ? MAXP : m_period + PS;
    if (bus.i_mode != 2'd1) begin
      m_st = 0; m_pos = 0; m_idx = 0;
    end else if (m_st == 0) begin
      if (bus.i_play_btn) begin
        m_st = 1; m_pos = 0; m_idx = 0; m_trig = pat(0); m_tick = 1;
      end
    end else if (m_st == 2) begin
      if (bus.i_play_btn) m_st = 1;
    end else begin
      m_pos++;
      if (m_pos >= m_period) begin
        m_pos = 0; m_idx = (m_idx + 1) % 8; m_trig = pat(m_idx); m_tick = 1;
      end
      if (bus.i_play_btn) m_st = 2;
    end
    m_period = np;
  endfunction
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("trig", 32'(bus.o_trig), m_trig);
    chk("step_tick", 32'(bus.o_step_tick), m_tick);
    chk("idx", 32'(bus.o_play_step_idx), m_idx);
    chk("playing", 32'(bus.o_playing), 32'(m_st == 1));
    chk("period", 32'(bus.o_period), m_period);
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic press();
    bus.i_play_btn = 1'b1;
    step();
    bus.i_play_btn = 1'b0;
  endtask
  initial begin
    bus.i_mode = 2'd0; bus.i_play_btn = 1'b0; bus.i_tempo_faster = 1'b0; bus.i_tempo_slower = 1'b0;
    bus.i_seq_smpl = {4'h5, 4'hF, 4'h0, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1};
    run(2);
    rst = 1'b0;
    chk("rst_period", 32'(bus.o_period), 4);
    chk("rst_idx", 32'(bus.o_play_step_idx), 0);
    bus.i_mode = 2'd1;
    step();
    press();
    chk("first_trig", 32'(bus.o_trig), 1);
    run(4);
    chk("second_trig", 32'(bus.o_trig), 2);
    run(16);
    chk("empty_step_tick", 32'(bus.o_step_tick), 1);
    chk("empty_step_trig", 32'(bus.o_trig), 0);
    run(12);
    chk("wrap_trig", 32'(bus.o_trig), 1);
    chk("wrap_idx", 32'(bus.o_play_step_idx), 0);
    rst = 1'b1; step(); rst = 1'b0;
    press();
    run(5);
    press();
    chk("pause_playing", 32'(bus.o_playing), 0);
    chk("pause_idx", 32'(bus.o_play_step_idx), 1);
    run(13);
    press();
    run(2);
    chk("resume_trig", 32'(bus.o_trig), 4);
    chk("resume_idx", 32'(bus.o_play_step_idx), 2);
    bus.i_mode = 2'd0;
    press();
    chk("leave_playing", 32'(bus.o_playing), 0);
    chk("leave_idx", 32'(bus.o_play_step_idx), 0);
    bus.i_mode = 2'd1;
    press();
    chk("reenter_trig", 32'(bus.o_trig), 1);
    bus.i_mode = 2'd0;
    step();
    bus.i_tempo_faster = 1'b1;
    step(); chk("faster1", 32'(bus.o_period), 2);
    step(); chk("faster_clamp", 32'(bus.o_period), 2);
    bus.i_tempo_faster = 1'b0; bus.i_tempo_slower = 1'b1;
    step(); chk("slower1", 32'(bus.o_period), 4);
    step(); chk("slower2", 32'(bus.o_period), 6);
    step(); chk("slower3", 32'(bus.o_period), 8);
    step(); chk("slower_clamp", 32'(bus.o_period), 8);
    bus.i_tempo_faster = 1'b1;
    step(); chk("both_hold", 32'(bus.o_period), 8);
    bus.i_tempo_faster = 1'b0; bus.i_tempo_slower = 1'b0;
    bus.i_mode = 2'd1;
    press();
    run(3);
    bus.i_tempo_faster = 1'b1;
    run(2);
    bus.i_tempo_faster = 1'b0;
    chk("shorten_period", 32'(bus.o_period), 4);
    step();
    chk("shorten_adv_trig", 32'(bus.o_trig), 2);
    chk("shorten_adv_idx", 32'(bus.o_play_step_idx), 1);
    run(4);
    chk("shorten_next_trig", 32'(bus.o_trig), 4);
    run(3);
    rst = 1'b1; bus.i_tempo_slower = 1'b1;
    step();
    rst = 1'b0; bus.i_tempo_slower = 1'b0;
    chk("midrst_trig", 32'(bus.o_trig), 0);
    chk("midrst_playing", 32'(bus.o_playing), 0);
    chk("midrst_idx", 32'(bus.o_play_step_idx), 0);
    chk("midrst_period", 32'(bus.o_period), 4);
    step();
    chk("midrst_next_trig", 32'(bus.o_trig), 0);
    repeat (3000) begin
      rst = ($urandom_range(199) == 0);
      bus.i_mode = ($urandom_range(9) == 0) ? 2'($urandom) : 2'd1;
      bus.i_play_btn = ($urandom_range(19) == 0);
      bus.i_tempo_faster = ($urandom_range(24) == 0);
      bus.i_tempo_slower = ($urandom_range(24) == 0);
      if ($urandom_range(7) == 0) bus.i_seq_smpl = $urandom;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/step_playback_engine.md
Name: step_playback_engine

Overview:
Playback stage downstream of the 8-step x 4-sample sequence editor. It consumes the eight 4-bit step patterns and, in play mode (mode == 2'd1), walks them at a programmable tempo. At each step boundary it issues one-cycle trigger pulses to the four sample voices. It also supplies the current step index to the display and LED logic.

Parameters:
CNT_W, 24, width of the tempo tick counter and period register
DEFAULT_PERIOD, 6_250_000, clocks per step after reset
MIN_PERIOD, 1_000_000, lower clamp on the step period (fastest tempo)
MAX_PERIOD, 12_500_000, upper clamp on the step period (slowest tempo)
PERIOD_STEP, 250_000, period change per tempo_faster or tempo_slower pulse

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
mode  in  2  global mode; 2'd1 = play, any other value forces STOPPED
play_btn  in  1  debounced one-cycle pulse; toggles play/pause
tempo_faster  in  1  one-cycle pulse; period -= PERIOD_STEP
tempo_slower  in  1  one-cycle pulse; period += PERIOD_STEP
seq_smpl_1..seq_smpl_8  in  4 each  step patterns; bit k enables voice k on that step
trig  out  4  one-cycle voice trigger pulses
step_tick  out  1  one-cycle pulse whenever trig is loaded, including when trig == 0
play_step_idx  out  3  step currently sounding, 0..7
playing  out  1  high in PLAYING only
period  out  CNT_W  current step period, for tempo display

Behaviour:
- Reset values: state = STOPPED, trig = 0, step_tick = 0, play_step_idx = 0, playing = 0, period = DEFAULT_PERIOD, tick_cnt = 0.
- All outputs are registered. trig and step_tick default to 0 every cycle and are high for exactly one cycle.
- pat(i) means the 4-bit pattern of step i (seq_smpl_{i+1}), sampled at the clock edge where it is loaded.
- States:
  - STOPPED: play_btn with mode == 1 -> PLAYING. On that edge: play_step_idx <= 0, tick_cnt <= 0, trig <= pat(0), step_tick <= 1. So the first trigger appears 1 cycle after play_btn.
  - PLAYING: tick_cnt increments each cycle. When tick_cnt >= period-1: tick_cnt <= 0, play_step_idx <= idx+1 (7 wraps to 0), trig <= pat(new idx), step_tick <= 1. Step spacing is exactly `period` cycles. play_btn -> PAUSED.
  - PAUSED: tick_cnt and play_step_idx are held. play_btn -> PLAYING and counting resumes from the held tick_cnt, with no retrigger on resume.
- mode != 1 in any state -> STOPPED on the next edge: play_step_idx <= 0, tick_cnt <= 0, no trig. This takes priority over play_btn in the same cycle.
- play_btn while mode != 1 is ignored.
- Tempo adjustment is active in all states, including STOPPED:
  - tempo_faster alone: period <= max(period - PERIOD_STEP, MIN_PERIOD).
  - tempo_slower alone: period <= min(period + PERIOD_STEP, MAX_PERIOD).
  - Both in the same cycle: no change.
  - Arithmetic is CNT_W+1 bits wide to avoid underflow/overflow before clamping.
- A new period takes effect from the cycle after it is registered. If a shortened period leaves tick_cnt >= new period-1, the step advances on that next cycle; the >= compare guarantees there is no 2^CNT_W wrap.
- Pattern changes are not latched: each step's trig reflects the pattern at the instant that step is loaded.
- rst asserted mid-play clears everything on that edge, and trig is 0 in the following cycle.

Test Plan:
(bench params: DEFAULT_PERIOD=4, MIN_PERIOD=2, MAX_PERIOD=8, PERIOD_STEP=2, CNT_W=4)
1. Reset, then mode=1, seq_smpl_1..8 = 1,2,4,8,3,0,F,5, play_btn at cycle T -> trig = 1 at T+1, 2 at T+5, 4 at T+9, ... 5 at T+29, 1 again at T+33. play_step_idx tracks 0..7..0. step_tick pulses at T+21 even though trig = 0 there.
2. Pause and resume: play_btn at T+6 (tick_cnt = 1) -> PAUSED, idx = 1, no pulses. play_btn at T+20 -> resumes, next trig = 4 at T+23 (2 cycles after resume).
3. Mode leave: mode=0 in the same cycle as play_btn while PLAYING -> STOPPED, idx = 0, playing = 0, no trig. Re-entering with mode=1 plus play_btn -> trig = pat(0) one cycle later.
4. Tempo clamp: two tempo_faster pulses from 4 -> period = 2 then 2. Four tempo_slower pulses -> 4, 6, 8, 8. tempo_faster together with tempo_slower -> unchanged.
5. Shorten mid-step: period 8, tick_cnt = 5, tempo_faster twice -> period = 4. Next cycle tick_cnt >= 3 so the step advances immediately; no missed or duplicated steps.
6. rst during PLAYING with trig pending -> all outputs at reset values the cycle after rst, and period = DEFAULT_PERIOD.
